// File: rtl/muldiv_div_seq.sv
// Sequential radix-2 restoring divider for the M-extension MUL/DIV unit.
// One quotient bit per cycle; signed/unsigned with RISC-V div-by-zero/overflow results.
module muldiv_div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_rdy,
   output logic             div_busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] p_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] a_raw;
   logic             q_neg;
   logic             r_neg;
   logic             d_zero;

   logic [WIDTH-1:0] p_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   always_comb begin
      p_sh  = {p_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      trial = {1'b0, p_sh} - {1'b0, d_reg};
      a_mag = dividend;
      b_mag = divisor;
      if (div_signed && dividend[WIDTH-1]) a_mag = -dividend;
      if (div_signed && divisor[WIDTH-1])  b_mag = -divisor;
   end

   assign div_busy = (state == ITER) || (state == FIX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         p_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         a_raw     <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         d_zero    <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_rdy   <= 1'b0;
      end else begin
         div_rdy <= 1'b0;
         case (state)
            // DONE samples a held start so back-to-back operations need no bubble.
            IDLE, DONE: begin
               if (div_start) begin
                  p_reg  <= '0;
                  q_reg  <= a_mag;
                  d_reg  <= b_mag;
                  a_raw  <= dividend;
                  q_neg  <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg  <= div_signed & dividend[WIDTH-1];
                  d_zero <= (divisor == '0);
                  cnt    <= '0;
                  state  <= ITER;
               end else begin
                  state  <= IDLE;
               end
            end
            ITER: begin
               q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
               p_reg <= trial[WIDTH] ? p_sh : trial[WIDTH-1:0];
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               if (d_zero) begin
                  quotient  <= '1;
                  remainder <= a_raw;
               end else begin
                  quotient  <= q_neg ? -q_reg : q_reg;
                  remainder <= r_neg ? -p_reg : p_reg;
               end
               div_rdy <= 1'b1;
               state   <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_div_seq.sv
// Self-checking bench for muldiv_div_seq: directed table, random ops against
// an arithmetic reference, and reset / start-handling sequences.
module tb_muldiv_div_seq;

   logic        clk;
   logic        reset;
   logic        div_start;
   logic        div_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_rdy;
   logic        div_busy;

   int errors = 0;
   int checks = 0;

   muldiv_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .div_start  (div_start),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_rdy    (div_rdy),
      .div_busy   (div_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: RISC-V division rules in plain arithmetic.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {q[31:0], r[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {uq, ur};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Controller-style op: start held until div_rdy, then dropped the same cycle.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input logic [31:0] eq, input logic [31:0] er);
      int n;
      int busy_n;
      dividend   = a;
      divisor    = b;
      div_signed = s;
      div_start  = 1'b1;
      step();  // E0
      n = 0;
      busy_n = div_busy ? 1 : 0;
      while (!div_rdy && n < 200) begin
         step();
         n++;
         if (div_busy) busy_n++;
      end
      div_start = 1'b0;
      chk({nm, "_latency"}, n, 33);
      chk({nm, "_busy_cycles"}, busy_n, 33);
      chk({nm, "_quotient"}, quotient, eq);
      chk({nm, "_remainder"}, remainder, er);
      step();  // E34
      chk({nm, "_rdy_one_cycle"}, {div_rdy, div_busy}, 2'b00);
   endtask

   vec_t tbl[10];

   initial begin
      logic [31:0] ra, rb;
      logic [63:0] exp;
      bit          rs;
      int          n;
      int          rdy_seen;

      tbl[0] = '{"u100_7",     32'd100,         32'd7,           1'b0, 32'd14,          32'd2};
      tbl[1] = '{"s_m7_2",     32'hFFFF_FFF9,   32'd2,           1'b1, 32'hFFFF_FFFD,   32'hFFFF_FFFF};
      tbl[2] = '{"s_7_m2",     32'd7,           32'hFFFF_FFFE,   1'b1, 32'hFFFF_FFFD,   32'd1};
      tbl[3] = '{"u_max_16",   32'hFFFF_FFFF,   32'h10,          1'b0, 32'h0FFF_FFFF,   32'hF};
      tbl[4] = '{"s_m5_0",     32'hFFFF_FFFB,   32'd0,           1'b1, 32'hFFFF_FFFF,   32'hFFFF_FFFB};
      tbl[5] = '{"u_9_0",      32'd9,           32'd0,           1'b0, 32'hFFFF_FFFF,   32'd9};
      tbl[6] = '{"s_ovf",      32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   32'd0};
      tbl[7] = '{"u_min_max",  32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 32'd0,           32'h8000_0000};
      tbl[8] = '{"u_0_5",      32'd0,           32'd5,           1'b0, 32'd0,           32'd0};
      tbl[9] = '{"s_m1_m1",    32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b1, 32'd1,           32'd0};

      reset      = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      dividend   = '0;
      divisor    = '0;
      #2;
      chk("reset_outputs", {quotient, remainder, 30'd0, div_rdy, div_busy}, 64'd0);
      step();
      step();
      reset = 1'b1;
      step();

      for (int i = 0; i < 10; i++)
         run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: rb = rb >> $urandom_range(0, 31);
            default: ;
         endcase
         exp = ref_div(ra, rb, rs);
         run_op("rand", ra, rb, rs, exp[63:32], exp[31:0]);
      end

      // Reset abort at E10 of an operation.
      dividend   = 32'd1000;
      divisor    = 32'd3;
      div_signed = 1'b0;
      div_start  = 1'b1;
      step();  // E0
      for (int i = 0; i < 10; i++) step();
      div_start = 1'b0;
      reset     = 1'b0;
      #1;
      chk("abort_outputs_zero", {quotient, remainder, 30'd0, div_rdy, div_busy}, 64'd0);
      step();
      step();
      reset = 1'b1;
      rdy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (div_rdy) rdy_seen++;
      end
      chk("abort_no_rdy", rdy_seen, 0);

      // 20 / 3 with start and operands toggling during ITER.
      dividend   = 32'd20;
      divisor    = 32'd3;
      div_signed = 1'b0;
      div_start  = 1'b1;
      step();  // E0
      n = 0;
      while (!div_rdy && n < 200) begin
         div_start  = 1'($urandom_range(0, 1));
         dividend   = $urandom;
         divisor    = $urandom;
         div_signed = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      div_start = 1'b0;
      chk("toggle_latency", n, 33);
      chk("toggle_quotient", quotient, 32'd6);
      chk("toggle_remainder", remainder, 32'd2);
      step();
      chk("toggle_idle_after", {div_rdy, div_busy}, 2'b00);

      // Back-to-back: start held through E34.
      dividend   = 32'd100;
      divisor    = 32'd7;
      div_signed = 1'b0;
      div_start  = 1'b1;
      step();  // E0
      n = 0;
      while (!div_rdy && n < 200) begin
         step();
         n++;
      end
      chk("b2b_first_latency", n, 33);
      chk("b2b_first_result", {quotient, remainder}, {32'd14, 32'd2});
      dividend = 32'd20;
      divisor  = 32'd3;
      step();  // E34
      n++;
      chk("b2b_no_bubble", {div_rdy, div_busy}, 2'b01);
      while (!div_rdy && n < 300) begin
         step();
         n++;
      end
      div_start = 1'b0;
      chk("b2b_second_latency", n, 67);
      chk("b2b_second_result", {quotient, remainder}, {32'd6, 32'd2});
      step();
      chk("b2b_idle_after", {div_rdy, div_busy}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
